// File: rtl/pht_counter_table.sv
// Gshare pattern history table of 2-bit saturating counters with a self-clearing init sweep,
// a 1-cycle lookup port and a two-stage read-modify-write training port.
module pht_counter_table #(
   parameter int INDEX_WIDTH = 8,
   parameter int HIST_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  ready,
   input  logic                  lookup_valid,
   input  logic [31:0]           lookup_pc,
   input  logic [HIST_WIDTH-1:0] lookup_bhr,
   output logic                  pred_valid,
   output logic                  pred_taken,
   output logic [1:0]            pred_cnt,
   input  logic                  update_valid,
   input  logic [31:0]           update_pc,
   input  logic [HIST_WIDTH-1:0] update_bhr,
   input  logic                  update_taken
);

   localparam int ENTRIES = 1 << INDEX_WIDTH;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [INDEX_WIDTH-1:0] r_init_idx;
   logic [1:0]             r_table [ENTRIES];

   logic                   w_run;
   logic [INDEX_WIDTH-1:0] w_lk_idx;
   logic [INDEX_WIDTH-1:0] w_up_idx;
   logic [1:0]             w_lk_cnt;

   logic                   r_u1_vld;
   logic [INDEX_WIDTH-1:0] r_u1_idx;
   logic                   r_u1_taken;
   logic [1:0]             w_u2_old;
   logic [1:0]             w_u2_new;
   logic                   w_u2_we;

   logic                   r_pred_vld;
   logic [1:0]             r_pred_cnt;

   logic                   w_unused;

   function automatic logic [INDEX_WIDTH-1:0] gshare(input logic [INDEX_WIDTH-1:0] pc_bits,
                                                     input logic [HIST_WIDTH-1:0]  bhr);
      logic [INDEX_WIDTH-1:0] ext;
      ext                 = '0;
      ext[HIST_WIDTH-1:0] = bhr;
      return pc_bits ^ ext;
   endfunction

   function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
      if (taken) return (cnt == 2'b11) ? 2'b11 : cnt + 2'd1;
      else       return (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_INIT;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_INIT && (&r_init_idx)) w_state_nxt = ST_RUN;
   end

   always_comb begin
      ready = (r_state == ST_RUN);
   end

   assign w_run = ready;

   always_ff @(posedge clk) begin
      if (rst)                    r_init_idx <= '0;
      else if (r_state == ST_INIT) r_init_idx <= r_init_idx + INDEX_WIDTH'(1);
   end

   assign w_lk_idx = gshare(lookup_pc[INDEX_WIDTH+2:3], lookup_bhr);
   assign w_up_idx = gshare(update_pc[INDEX_WIDTH+2:3], update_bhr);

   // U1: capture the training request
   always_ff @(posedge clk) begin
      if (rst) r_u1_vld <= 1'b0;
      else     r_u1_vld <= update_valid && w_run;
      r_u1_idx   <= w_up_idx;
      r_u1_taken <= update_taken;
   end

   // U2: read-modify-write; a reset in this cycle drops the pending write
   assign w_u2_old = r_table[r_u1_idx];
   assign w_u2_new = sat_next(w_u2_old, r_u1_taken);
   assign w_u2_we  = r_u1_vld && !rst;

   always_ff @(posedge clk) begin
      if (r_state == ST_INIT) r_table[r_init_idx] <= 2'b01;
      else if (w_u2_we)       r_table[r_u1_idx]   <= w_u2_new;
   end

   // Lookup read is write-first against the U2 write in the same cycle
   assign w_lk_cnt = (w_u2_we && (r_u1_idx == w_lk_idx)) ? w_u2_new : r_table[w_lk_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pred_vld <= 1'b0;
         r_pred_cnt <= 2'b01;
      end else begin
         r_pred_vld <= lookup_valid && w_run;
         if (lookup_valid && w_run) r_pred_cnt <= w_lk_cnt;
      end
   end

   assign pred_valid = r_pred_vld;
   assign pred_cnt   = r_pred_cnt;
   assign pred_taken = r_pred_cnt[1];

   assign w_unused = ^{lookup_pc[31:INDEX_WIDTH+3], lookup_pc[2:0],
                       update_pc[31:INDEX_WIDTH+3], update_pc[2:0]};

endmodule

// File: doc/pht_counter_table.md
Name: pht_counter_table

Overview:
- Pattern history table that consumes the per-PC branch history produced by the branch history table and turns it into a taken/not-taken prediction.
- Holds 2-bit saturating counters indexed by gshare hash of fetch PC and history. Hash is pc[INDEX_WIDTH+2:3] XOR history.
- Lookup side serves fetch with 1-cycle latency. Update side is trained at branch resolution, alongside the BHT shift-in.
- Self-initialising after reset via an internal sweep FSM.

Parameters:
- INDEX_WIDTH, 8, log2 of counter entries (256 entries).
- HIST_WIDTH, 8, width of branch history input; must be <= INDEX_WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- ready  output  1  high when the init sweep is done and the table accepts traffic.
- lookup_valid  input  1  lookup request.
- lookup_pc  input  32  fetch PC.
- lookup_bhr  input  HIST_WIDTH  history for the lookup PC.
- pred_valid  output  1  prediction valid, one cycle after an accepted lookup.
- pred_taken  output  1  prediction; equals pred_cnt[1].
- pred_cnt  output  2  counter value read.
- update_valid  input  1  training request from branch resolution.
- update_pc  input  32  resolved branch PC.
- update_bhr  input  HIST_WIDTH  history used when that branch was predicted.
- update_taken  input  1  resolved direction.

Behaviour:
- Clocking and reset: single clock domain, clk. rst is synchronous, active-high.
- Index: idx = pc[INDEX_WIDTH+2:3] XOR zero-extended bhr. Bhr occupies the low bits. Same rule on lookup and update.
- FSM states: INIT and RUN.
- rst high, at any time: state goes to INIT, init_idx=0, pending update dropped. Outputs: pred_valid=0, pred_taken=0, pred_cnt=2'b01, ready=0.
- INIT: each cycle writes 2'b01 (weakly not-taken) to entry init_idx, then increments init_idx. After writing entry 2^INDEX_WIDTH-1, go to RUN. ready=1 from the first RUN cycle, exactly 2^INDEX_WIDTH cycles after the first cycle with rst low.
- In INIT, lookup_valid and update_valid are ignored: no pred_valid, no table change.
- Lookup: lookup_valid in cycle t (RUN) -> pred_valid=1 in t+1 with the counter for idx. pred_valid=0 in any cycle not following an accepted lookup. pred_cnt/pred_taken hold their last value when pred_valid=0.
- Update pipeline, stage U1: update_valid in cycle t (RUN) registers idx and taken.
- Update pipeline, stage U2 (cycle t+1): reads the counter, computes the new value, writes it at the end of t+1.
- Saturating rule, taken: 00->01->10->11; 11 stays 11.
- Saturating rule, not taken: 11->10->01->00; 00 stays 00.
- Back-to-back updates to the same idx in consecutive cycles: U2 of the second update reads after the first write has landed, so both take effect cumulatively.
- Bypass: a lookup in the same cycle as a U2 write to the same idx returns the newly written value (write-first).
- Simultaneous lookup and update to different indices: both proceed independently, with no stall.
- Throughput: one lookup and one update accepted per cycle in RUN; there is no backpressure besides ready.

Test Plan:
1. Reset init: pulse rst for 1 cycle, then drive lookup_valid every cycle.
   - ready must rise 256 cycles after rst falls; pred_valid=0 throughout INIT.
   - First RUN lookups of any idx give pred_cnt=01, pred_taken=0.
2. Saturation up/down, pc=0x1C000008, bhr=0 (idx=0x01):
   - 3 taken updates, then lookup -> pred_cnt=11, pred_taken=1.
   - 4 more taken leave 11.
   - 4 not-taken, then lookup -> pred_cnt=00.
   - 1 more not-taken leaves 00.
3. Write-first bypass: entry at 01, update taken in cycle t, lookup the same idx in t+1 -> pred_cnt=10 in t+2.
4. XOR aliasing: update taken with pc=0x00000028 (pc idx 0x05), bhr=0x05 (idx 0x00). Lookup pc=0x00000000, bhr=0 -> pred_cnt=10. Lookup pc=0x28, bhr=0 (idx 0x05) -> pred_cnt=01.
5. Reset mid-operation: train idx 0x01 to 11, issue an update, and assert rst in the following cycle.
   - Pending update must not land.
   - After the re-sweep, lookup idx 0x01 -> pred_cnt=01.
6. Back-to-back updates: two taken updates to idx 0x02 in consecutive cycles from 01, then lookup -> pred_cnt=11. Updates issued during INIT produce no change.
